signed_alu: RTL and testbench

Registered 16-bit signed ALU with four function units (arithmetic, logic, compare, shift) selected by a 4-bit opcode. Each unit drives its own result bus and valid flag. Only the unit addressed by the upper two opcode bits updates on a clock edge. It sits as a leaf datapath block behind any controller that presents operands and an opcode each cycle.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/signed_alu_if.sv | 24 ++
 rtl/alu_arith.sv | 48 ++++
 rtl/alu_cmp.sv | 45 ++++
 rtl/alu_decoder.sv | 18 +
 rtl/alu_logic.sv | 45 ++++
 rtl/alu_shift.sv | 45 ++++
 rtl/signed_alu.sv | 35 +++
 tb/tb_signed_alu.sv | 142 ++++++++++++++
 9 files changed

// File: rtl/alu_pkg.sv
// Shared widths, unit-select codes, opcodes and compare result codes
// for the registered signed ALU.
package alu_pkg;

   localparam int OP_DATA_WIDTH   = 16;
   localparam int ARITH_OUT_WIDTH = 2 * OP_DATA_WIDTH;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_NOP  = 4'b1000;
   localparam logic [3:0] OP_CEQ  = 4'b1001;
   localparam logic [3:0] OP_CGT  = 4'b1010;
   localparam logic [3:0] OP_CLT  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;
   localparam logic [3:0] OP_SLA  = 4'b1101;
   localparam logic [3:0] OP_SRB  = 4'b1110;
   localparam logic [3:0] OP_SLB  = 4'b1111;

   localparam logic [OP_DATA_WIDTH-1:0] CMP_EQ = 16'd1;
   localparam logic [OP_DATA_WIDTH-1:0] CMP_GT = 16'd2;
   localparam logic [OP_DATA_WIDTH-1:0] CMP_LT = 16'd3;

endpackage

// File: rtl/signed_alu_if.sv
// Operand/opcode inputs and per-unit result buses of the signed ALU.
interface signed_alu_if
   import alu_pkg::*;
   ();
   logic signed [OP_DATA_WIDTH-1:0]   A;
   logic signed [OP_DATA_WIDTH-1:0]   B;
   logic        [3:0]                 ALU_FUN;
   logic signed [ARITH_OUT_WIDTH-1:0] Arith_OUT;
   logic        [OP_DATA_WIDTH-1:0]   Logic_Out;
   logic        [OP_DATA_WIDTH-1:0]   CMP_Out;
   logic        [OP_DATA_WIDTH-1:0]   Shift_Out;
   logic                              Arith_Flag;
   logic                              Logic_Flag;
   logic                              CMP_Flag;
   logic                              Shift_Flag;

   modport master (output A, B, ALU_FUN,
                   input  Arith_OUT, Logic_Out, CMP_Out, Shift_Out,
                          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag);

   modport slave  (input  A, B, ALU_FUN,
                   output Arith_OUT, Logic_Out, CMP_Out, Shift_Out,
                          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag);
endinterface

// File: rtl/alu_arith.sv
// Signed add/sub/mul/div unit; result and flag clear when not enabled.
module alu_arith
   import alu_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_i,
   input  logic        [3:0]                 fun_i,
   input  logic signed [OP_DATA_WIDTH-1:0]   a_i,
   input  logic signed [OP_DATA_WIDTH-1:0]   b_i,
   output logic signed [ARITH_OUT_WIDTH-1:0] result_o,
   output logic                              flag_o
);
   logic signed [ARITH_OUT_WIDTH-1:0] a_ext_s, b_ext_s, res_d, res_q;
   logic                              flag_d, flag_q;

   // 32-bit operands make -32768/-1 and the full product representable
   always_comb begin
      a_ext_s = ARITH_OUT_WIDTH'(a_i);
      b_ext_s = ARITH_OUT_WIDTH'(b_i);
      res_d   = 32'sd0;
      flag_d  = en_i;
      if (en_i) begin
         case (fun_i)
            OP_ADD:  res_d = a_ext_s + b_ext_s;
            OP_SUB:  res_d = a_ext_s - b_ext_s;
            OP_MUL:  res_d = a_ext_s * b_ext_s;
            OP_DIV:  res_d = (b_ext_s == 32'sd0) ? 32'sd0 : (a_ext_s / b_ext_s);
            default: res_d = 32'sd0;
         endcase
      end else begin
         res_d = 32'sd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q  <= 32'sd0;
         flag_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         flag_q <= flag_d;
      end
   end

   assign result_o = res_q;
   assign flag_o   = flag_q;
endmodule

// File: rtl/alu_cmp.sv
// Signed compare unit producing EQ/GT/LT codes; clears when not enabled.
module alu_cmp
   import alu_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en_i,
   input  logic [3:0]                      fun_i,
   input  logic signed [OP_DATA_WIDTH-1:0] a_i,
   input  logic signed [OP_DATA_WIDTH-1:0] b_i,
   output logic [OP_DATA_WIDTH-1:0]        result_o,
   output logic                            flag_o
);
   logic [OP_DATA_WIDTH-1:0] res_d, res_q;
   logic                     flag_d, flag_q;

   always_comb begin
      res_d  = 16'h0000;
      flag_d = en_i;
      if (en_i) begin
         case (fun_i)
            OP_NOP:  res_d = 16'h0000;
            OP_CEQ:  res_d = (a_i == b_i) ? CMP_EQ : 16'h0000;
            OP_CGT:  res_d = (a_i >  b_i) ? CMP_GT : 16'h0000;
            OP_CLT:  res_d = (a_i <  b_i) ? CMP_LT : 16'h0000;
            default: res_d = 16'h0000;
         endcase
      end else begin
         res_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q  <= 16'h0000;
         flag_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         flag_q <= flag_d;
      end
   end

   assign result_o = res_q;
   assign flag_o   = flag_q;
endmodule

// File: rtl/alu_decoder.sv
// Decodes the unit-select field into one-hot unit enables.
module alu_decoder
   import alu_pkg::*;
(
   input  logic [1:0] sel_i,
   output logic [3:0] en_o
);
   always_comb begin
      en_o = 4'b0000;
      case (sel_i)
         UNIT_ARITH: en_o = 4'b0001;
         UNIT_LOGIC: en_o = 4'b0010;
         UNIT_CMP:   en_o = 4'b0100;
         UNIT_SHIFT: en_o = 4'b1000;
         default:    en_o = 4'b0000;
      endcase
   end
endmodule

// File: rtl/alu_logic.sv
// Bitwise AND/OR/NAND/NOR unit; result and flag clear when not enabled.
module alu_logic
   import alu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic [3:0]               fun_i,
   input  logic [OP_DATA_WIDTH-1:0] a_i,
   input  logic [OP_DATA_WIDTH-1:0] b_i,
   output logic [OP_DATA_WIDTH-1:0] result_o,
   output logic                     flag_o
);
   logic [OP_DATA_WIDTH-1:0] res_d, res_q;
   logic                     flag_d, flag_q;

   always_comb begin
      res_d  = 16'h0000;
      flag_d = en_i;
      if (en_i) begin
         case (fun_i)
            OP_AND:  res_d = a_i & b_i;
            OP_OR:   res_d = a_i | b_i;
            OP_NAND: res_d = ~(a_i & b_i);
            OP_NOR:  res_d = ~(a_i | b_i);
            default: res_d = 16'h0000;
         endcase
      end else begin
         res_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q  <= 16'h0000;
         flag_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         flag_q <= flag_d;
      end
   end

   assign result_o = res_q;
   assign flag_o   = flag_q;
endmodule

// File: rtl/alu_shift.sv
// One-position logical shift unit (zero fill); clears when not enabled.
module alu_shift
   import alu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic [3:0]               fun_i,
   input  logic [OP_DATA_WIDTH-1:0] a_i,
   input  logic [OP_DATA_WIDTH-1:0] b_i,
   output logic [OP_DATA_WIDTH-1:0] result_o,
   output logic                     flag_o
);
   logic [OP_DATA_WIDTH-1:0] res_d, res_q;
   logic                     flag_d, flag_q;

   always_comb begin
      res_d  = 16'h0000;
      flag_d = en_i;
      if (en_i) begin
         case (fun_i)
            OP_SRA:  res_d = {1'b0, a_i[15:1]};
            OP_SLA:  res_d = {a_i[14:0], 1'b0};
            OP_SRB:  res_d = {1'b0, b_i[15:1]};
            OP_SLB:  res_d = {b_i[14:0], 1'b0};
            default: res_d = 16'h0000;
         endcase
      end else begin
         res_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q  <= 16'h0000;
         flag_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         flag_q <= flag_d;
      end
   end

   assign result_o = res_q;
   assign flag_o   = flag_q;
endmodule

// File: rtl/signed_alu.sv
// Registered 16-bit signed ALU: decoder plus four self-clearing function units.
module signed_alu
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   signed_alu_if.slave  bus
);
   logic [3:0] unit_en_s;

   alu_decoder u_dec (
      .sel_i (bus.ALU_FUN[3:2]),
      .en_o  (unit_en_s)
   );

   alu_arith u_arith (
      .clk(clk), .rst(rst), .en_i(unit_en_s[0]), .fun_i(bus.ALU_FUN),
      .a_i(bus.A), .b_i(bus.B), .result_o(bus.Arith_OUT), .flag_o(bus.Arith_Flag)
   );

   alu_logic u_logic (
      .clk(clk), .rst(rst), .en_i(unit_en_s[1]), .fun_i(bus.ALU_FUN),
      .a_i(bus.A), .b_i(bus.B), .result_o(bus.Logic_Out), .flag_o(bus.Logic_Flag)
   );

   alu_cmp u_cmp (
      .clk(clk), .rst(rst), .en_i(unit_en_s[2]), .fun_i(bus.ALU_FUN),
      .a_i(bus.A), .b_i(bus.B), .result_o(bus.CMP_Out), .flag_o(bus.CMP_Flag)
   );

   alu_shift u_shift (
      .clk(clk), .rst(rst), .en_i(unit_en_s[3]), .fun_i(bus.ALU_FUN),
      .a_i(bus.A), .b_i(bus.B), .result_o(bus.Shift_Out), .flag_o(bus.Shift_Flag)
   );
endmodule

// File: tb/tb_signed_alu.sv
// Directed self-checking bench for signed_alu with hand-computed expectations.
module tb_signed_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   signed_alu_if bus ();

   signed_alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every bus is checked: the selected one against exp, the others against zero.
   task automatic check_outputs(input string tag, input logic [1:0] unit, input logic [31:0] exp);
      logic [31:0] e_ar, e_lo, e_cm, e_sh;
      logic [3:0]  e_fl;
      e_ar = (unit == 2'd0) ? exp : 32'h0;
      e_lo = (unit == 2'd1) ? exp : 32'h0;
      e_cm = (unit == 2'd2) ? exp : 32'h0;
      e_sh = (unit == 2'd3) ? exp : 32'h0;
      e_fl = 4'b1000 >> unit;
      check({tag, "_arith"}, bus.Arith_OUT, e_ar);
      check({tag, "_logic"}, {16'h0, bus.Logic_Out}, e_lo);
      check({tag, "_cmp"},   {16'h0, bus.CMP_Out},   e_cm);
      check({tag, "_shift"}, {16'h0, bus.Shift_Out}, e_sh);
      check({tag, "_flags"}, {28'h0, bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag},
            {28'h0, e_fl});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_arith"}, bus.Arith_OUT, 32'h0);
      check({tag, "_logic"}, {16'h0, bus.Logic_Out}, 32'h0);
      check({tag, "_cmp"},   {16'h0, bus.CMP_Out},   32'h0);
      check({tag, "_shift"}, {16'h0, bus.Shift_Out}, 32'h0);
      check({tag, "_flags"}, {28'h0, bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag},
            32'h0);
   endtask

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] fun, input logic [1:0] unit, input logic [31:0] exp);
      @(negedge clk);
      bus.A       = a;
      bus.B       = b;
      bus.ALU_FUN = fun;
      @(posedge clk);
      #1;
      check_outputs(tag, unit, exp);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.A       = 16'sd5;
      bus.B       = 16'sd6;
      bus.ALU_FUN = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");

      @(negedge clk);
      rst = 1'b0;

      do_op("and",  16'd5, 16'd6, OP_AND,  2'd1, 32'h0000_0004);
      do_op("or",   16'd5, 16'd6, OP_OR,   2'd1, 32'h0000_0007);
      do_op("nand", 16'd5, 16'd6, OP_NAND, 2'd1, 32'h0000_FFFB);
      do_op("nor",  16'd5, 16'd6, OP_NOR,  2'd1, 32'h0000_FFF8);

      do_op("nop",  16'd5, 16'd6, OP_NOP, 2'd2, 32'h0);
      do_op("ceq",  16'd5, 16'd6, OP_CEQ, 2'd2, 32'h0);
      do_op("ceq1", 16'd7, 16'd7, OP_CEQ, 2'd2, 32'h1);
      do_op("cgt",  16'd5, 16'd6, OP_CGT, 2'd2, 32'h0);
      do_op("clt",  16'd5, 16'd6, OP_CLT, 2'd2, 32'h3);
      do_op("cgtn", 16'hFFFC, 16'hFFFB, OP_CGT, 2'd2, 32'h2);
      do_op("cltn", 16'hFFFC, 16'h0001, OP_CLT, 2'd2, 32'h3);

      do_op("sra",  16'd5, 16'd6, OP_SRA, 2'd3, 32'd2);
      do_op("sla",  16'd5, 16'd6, OP_SLA, 2'd3, 32'd10);
      do_op("srb",  16'd5, 16'd6, OP_SRB, 2'd3, 32'd3);
      do_op("slb",  16'd5, 16'd6, OP_SLB, 2'd3, 32'd12);
      do_op("sra8", 16'h8001, 16'd6, OP_SRA, 2'd3, 32'h0000_4000);
      do_op("sla8", 16'h8001, 16'd6, OP_SLA, 2'd3, 32'h0000_0002);

      do_op("add_nn", 16'hFFFC, 16'hFFFB, OP_ADD, 2'd0, 32'hFFFF_FFF7);
      do_op("add_pn", 16'h0004, 16'hFFFB, OP_ADD, 2'd0, 32'hFFFF_FFFF);
      do_op("add_np", 16'hFFFC, 16'h0005, OP_ADD, 2'd0, 32'h0000_0001);
      do_op("add_pp", 16'h0004, 16'h0005, OP_ADD, 2'd0, 32'h0000_0009);
      do_op("sub_nn", 16'hFFFC, 16'hFFFB, OP_SUB, 2'd0, 32'h0000_0001);
      do_op("sub_pn", 16'h0004, 16'hFFFB, OP_SUB, 2'd0, 32'h0000_0009);
      do_op("sub_np", 16'hFFFC, 16'h0005, OP_SUB, 2'd0, 32'hFFFF_FFF7);
      do_op("sub_pp", 16'h0004, 16'h0005, OP_SUB, 2'd0, 32'hFFFF_FFFF);
      do_op("add_big", 16'h7FFF, 16'h7FFF, OP_ADD, 2'd0, 32'h0000_FFFE);

      do_op("mul_nn", 16'hFFFC, 16'hFFFB, OP_MUL, 2'd0, 32'h0000_0014);
      do_op("mul_pn", 16'h0004, 16'hFFFB, OP_MUL, 2'd0, 32'hFFFF_FFEC);
      do_op("mul_max", 16'h8000, 16'h8000, OP_MUL, 2'd0, 32'h4000_0000);
      do_op("div_np", 16'hFFFC, 16'h0005, OP_DIV, 2'd0, 32'h0);
      do_op("div_pn", 16'h0004, 16'hFFFB, OP_DIV, 2'd0, 32'h0);
      do_op("div_trunc", 16'hFFEC, 16'h0006, OP_DIV, 2'd0, 32'hFFFF_FFFD);
      do_op("div_zero", 16'h0007, 16'h0000, OP_DIV, 2'd0, 32'h0);
      do_op("div_min", 16'h8000, 16'hFFFF, OP_DIV, 2'd0, 32'h0000_8000);

      // Inputs changing between edges must not disturb the held result.
      do_op("hold_pre", 16'd5, 16'd6, OP_OR, 2'd1, 32'h0000_0007);
      #2;
      bus.A       = 16'd0;
      bus.ALU_FUN = OP_SLB;
      #1;
      check_outputs("hold_mid", 2'd1, 32'h0000_0007);

      do_op("pre_rst", 16'd5, 16'd6, OP_MUL, 2'd0, 32'h0000_001E);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge clk);
      #1;
      check_zero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      do_op("post_rst", 16'd5, 16'd6, OP_SRB, 2'd3, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
